arbiter_puf_engine: RTL and testbench
=====================================

# arbiter_puf_engine

Parametrised multi-chain XOR arbiter PUF with an on-chip evaluation sequencer. It replaces the free-running, clock-launched single arbiter chain. It drives its own launch edge, evaluates N_CHAINS delay chains per challenge and XORs their arbiter outputs. Each bit is majority-voted over N_EVAL repeated evaluations, and challenges are stepped from a seed to assemble a RESP_BITS-wide response. It sits between the tile's input/output pins and the analog-ish mux/arbiter fabric.

## Interface
- C_LENGTH, 16: mux stages per chain; also the challenge/seed width.
- N_CHAINS, 2: parallel chains whose arbiter bits are XORed; must be at least 1.
- N_EVAL, 5: evaluations per response bit; must be odd.
- RESP_BITS, 8: response bits per request.
- SETTLE_CYC, 4: clk cycles per launch phase; must be at least 3.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- seed  in  C_LENGTH  initial challenge, captured on the start cycle.
- busy  out  1  high from the accepted start until completion.
- resp_valid  out  1  response stable; held until the next accepted start.
- response  out  RESP_BITS  assembled response; bit 0 is the first bit produced.
- unstable_cnt  out  clog2(RESP_BITS+1)  count of bits with non-unanimous votes.

## Operation
- Reset: FSM goes to IDLE; launch=0; busy=0, resp_valid=0, response=0, unstable_cnt=0; vote, bit, eval and settle counters are 0.
- Challenge register `chal`:
  - Loaded with seed on the accepted start.
  - After each decided bit it steps to next = {chal[C_LENGTH-2:0], chal[C_LENGTH-1]^chal[0]}.
  - Chain j receives chal rotated left by j.
- Each chain is a C_LENGTH-stage crossed mux pair plus an edge-triggered arbiter flop.
  - Both chain inputs are driven by register `launch`.
  - Arbiter outputs form `arb_q[N_CHAINS-1:0]`. This is a fixed hierarchical name and the bench forces it.
  - The arbiters are not reset.
- `arb_q` passes through a 2-flop synchroniser into clk. The evaluated bit is the XOR-reduction of the synchronised vector.
- FSM states:
  - IDLE: start=1 → ARM. Capture seed; clear response, unstable_cnt and counters; busy←1; resp_valid←0.
  - ARM: launch=0 for SETTLE_CYC cycles → FIRE.
  - FIRE: launch=1 for SETTLE_CYC cycles. On the last cycle, sample the XOR bit and add it to `ones`. If eval counter < N_EVAL-1 → ARM with eval+1; else → DECIDE.
  - DECIDE, 1 cycle:
    - bit = (ones > N_EVAL/2); write it into response[bit_idx].
    - If ones is neither 0 nor N_EVAL, unstable_cnt+1.
    - Step chal; clear ones and eval.
    - If bit_idx = RESP_BITS-1 → IDLE with busy←0 and resp_valid←1; else bit_idx+1 → ARM.
- start while busy: ignored; no restart and no queueing.
- Width rules:
  - `ones` is clog2(N_EVAL+1) bits and cannot overflow.
  - bit_idx is clog2(RESP_BITS) bits and never wraps in operation.
- Reset mid-operation: immediate abort to the reset values; the partial response is discarded.

## Timing
- Start accepted at edge 0; busy=1 after edge 0.
- One evaluation takes 2·SETTLE_CYC cycles. One bit takes N_EVAL·2·SETTLE_CYC + 1 cycles.
- busy falls and resp_valid rises after edge RESP_BITS·(2·SETTLE_CYC·N_EVAL+1). With defaults this is edge 328.
- response[k] updates at the end of the k-th DECIDE and holds thereafter.
- Launch rising edge to sample: SETTLE_CYC-1 cycles. This covers the 2 synchroniser stages plus chain settling.

## Configuration
- PUF_STABILITY_EN defined: the unstable_cnt logic is present and behaves as specified above.
- PUF_STABILITY_EN undefined: unstable_cnt is tied to 0 and its counter is removed. All other behaviour and timing are identical.

## Test plan
- Defaults, force arb_q=2'b11 on every evaluation, start with seed=16'h8001 → response=8'h00, unstable_cnt=0, resp_valid rises exactly 328 cycles after start.
- Force arb_q=2'b01 constantly → response=8'hFF; with PUF_STABILITY_EN, unstable_cnt=0.
- Per bit, force XOR=1 on evaluations 0,2,4 and XOR=0 on 1,3 → each bit=1, response=8'hFF, unstable_cnt=8 with the macro and 0 without it.
- Seed=16'h8001 → chain 0 challenge reads 16'h8001 during bit 0 and 16'h0002 during bit 1; chain 1 reads 16'h0003 during bit 0.
- Pulse start again at cycle 100 while busy → ignored; completion still occurs at cycle 328 with the original seed's result.
- Assert rst_n=0 at cycle 150 → busy, resp_valid, response and launch are 0 asynchronously. A new start then completes normally 328 cycles later.

Source files
------------

// File: rtl/arbiter_puf_engine.sv
// Multi-chain XOR arbiter PUF with its own launch sequencer and majority voting.
// Optional feature macro: PUF_STABILITY_EN (enables the unstable-bit counter).

module puf_chain #(
    parameter int C_LENGTH = 16
) (
    input  logic                launch,
    input  logic [C_LENGTH-1:0] chal,
    output logic                q
);
    logic top_path;
    logic bot_path;

    // Crossed mux pair per stage: a set challenge bit swaps the two racing paths.
    always_comb begin
        top_path = launch;
        bot_path = launch;
        for (int i = 0; i < C_LENGTH; i++) begin
            if (chal[i]) {top_path, bot_path} = {bot_path, top_path};
        end
    end

    // Arbiter: records which edge won the race; deliberately unreset.
    always_ff @(posedge bot_path) q <= top_path;
endmodule

module arbiter_puf_engine #(
    parameter int C_LENGTH   = 16,
    parameter int N_CHAINS   = 2,
    parameter int N_EVAL     = 5,
    parameter int RESP_BITS  = 8,
    parameter int SETTLE_CYC = 4,
    localparam int UW        = $clog2(RESP_BITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [C_LENGTH-1:0]  seed,
    output logic                 busy,
    output logic                 resp_valid,
    output logic [RESP_BITS-1:0] response,
    output logic [UW-1:0]        unstable_cnt
);
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int EW = (N_EVAL > 1) ? $clog2(N_EVAL) : 1;
    localparam int OW = $clog2(N_EVAL + 1);
    localparam int BW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [EW-1:0] EV_LAST  = EW'(N_EVAL - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(RESP_BITS - 1);
    localparam logic [OW-1:0] HALF     = OW'(N_EVAL / 2);
    localparam logic [OW-1:0] ALL      = OW'(N_EVAL);

    typedef enum logic [1:0] {IDLE, ARM, FIRE, DECIDE} state_t;

    state_t                             state, nxt;
    logic                               launch;
    logic [C_LENGTH-1:0]                chal;
    logic [N_CHAINS-1:0][C_LENGTH-1:0]  chain_chal;
    logic [N_CHAINS-1:0]                arb_q;
    logic [N_CHAINS-1:0]                sync1, sync2;
    logic [CW-1:0]                      cnt;
    logic [EW-1:0]                      ev;
    logic [OW-1:0]                      ones;
    logic [BW-1:0]                      bit_idx;
    logic                               xbit;
    logic                               vote;
    logic [C_LENGTH-1:0]                chal_step;

    for (genvar j = 0; j < N_CHAINS; j++) begin : g_chain
        localparam int ROT = j % C_LENGTH;
        assign chain_chal[j] = (chal << ROT) | (chal >> ((C_LENGTH - ROT) % C_LENGTH));
        puf_chain #(.C_LENGTH(C_LENGTH)) u_chain (
            .launch (launch),
            .chal   (chain_chal[j]),
            .q      (arb_q[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= arb_q;
            sync2 <= sync1;
        end
    end

    assign xbit      = ^sync2;
    assign vote      = (ones > HALF);
    assign chal_step = {chal[C_LENGTH-2:0], chal[C_LENGTH-1] ^ chal[0]};

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = ARM;
            ARM:     if (cnt == CNT_LAST) nxt = FIRE;
            FIRE:    if (cnt == CNT_LAST) nxt = (ev == EV_LAST) ? DECIDE : ARM;
            DECIDE:  nxt = (bit_idx == BIT_LAST) ? IDLE : ARM;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            launch     <= 1'b0;
            chal       <= '0;
            cnt        <= '0;
            ev         <= '0;
            ones       <= '0;
            bit_idx    <= '0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            response   <= '0;
        end else begin
            state  <= nxt;
            // Launch is high for exactly the FIRE cycles.
            launch <= (nxt == FIRE);
            case (state)
                IDLE: if (start) begin
                    chal       <= seed;
                    cnt        <= '0;
                    ev         <= '0;
                    ones       <= '0;
                    bit_idx    <= '0;
                    response   <= '0;
                    busy       <= 1'b1;
                    resp_valid <= 1'b0;
                end
                ARM: cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                FIRE: begin
                    if (cnt == CNT_LAST) begin
                        cnt  <= '0;
                        ones <= ones + OW'(xbit);
                        if (ev != EV_LAST) ev <= ev + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DECIDE: begin
                    response[bit_idx] <= vote;
                    chal              <= chal_step;
                    ones              <= '0;
                    ev                <= '0;
                    if (bit_idx == BIT_LAST) begin
                        busy       <= 1'b0;
                        resp_valid <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PUF_STABILITY_EN
    logic [UW-1:0] unst_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            unst_q <= '0;
        else if (state == IDLE && start)
            unst_q <= '0;
        else if (state == DECIDE && ones != '0 && ones != ALL)
            unst_q <= unst_q + 1'b1;
    end
    assign unstable_cnt = unst_q;
`else
    assign unstable_cnt = '0;
`endif
endmodule

// File: tb/tb_arbiter_puf_engine.sv
// Scoreboard bench for arbiter_puf_engine: arb_q forced per evaluation, results popped on resp_valid.

module tb_arbiter_puf_engine;
    localparam int C_LENGTH  = 16;
    localparam int N_EVAL    = 5;
    localparam int RESP_BITS = 8;
    localparam int UW        = $clog2(RESP_BITS + 1);
    localparam int LATENCY   = RESP_BITS * (2 * 4 * N_EVAL + 1);

    typedef struct {
        logic [RESP_BITS-1:0] resp;
        logic [UW-1:0]        unst;
        int                   lat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [C_LENGTH-1:0]  seed = '0;
    logic                 busy, resp_valid;
    logic [RESP_BITS-1:0] response;
    logic [UW-1:0]        unstable_cnt;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_cnt = 0;
    int   mode = 0;
    int   ev_cnt = 0;
    logic prev_rv = 1'b0;
    exp_t sb[$];

    arbiter_puf_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .seed         (seed),
        .busy         (busy),
        .resp_valid   (resp_valid),
        .response     (response),
        .unstable_cnt (unstable_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [C_LENGTH-1:0] step(input logic [C_LENGTH-1:0] c);
        return {c[C_LENGTH-2:0], c[C_LENGTH-1] ^ c[0]};
    endfunction

    // Arbiter pattern: 0 -> both chains 1 (XOR 0), 1 -> XOR 1, 2 -> XOR 1 on even evaluations only.
    initial begin
        force dut.arb_q = 2'b11;
        forever begin
            @(posedge dut.launch);
            if (mode == 0) force dut.arb_q = 2'b11;
            else if (mode == 1) force dut.arb_q = 2'b01;
            else if (ev_cnt % 2 == 0) force dut.arb_q = 2'b01;
            else force dut.arb_q = 2'b00;
            ev_cnt = (ev_cnt + 1) % N_EVAL;
        end
    end

    // Monitor: pop expected result on every resp_valid rise.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (resp_valid && !prev_rv) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_empty: unexpected response %h", response);
                end else begin
                    e = sb.pop_front();
                    total++;
                    if (response !== e.resp) begin
                        bad++; $display("FAIL response: got %h want %h", response, e.resp);
                    end
                    total++;
                    if (unstable_cnt !== e.unst) begin
                        bad++; $display("FAIL unstable_cnt: got %0d want %0d", unstable_cnt, e.unst);
                    end
                    total++;
                    if (cyc - start_cyc !== e.lat) begin
                        bad++; $display("FAIL latency: got %0d want %0d", cyc - start_cyc, e.lat);
                    end
                    total++;
                    if (busy !== 1'b0) begin
                        bad++; $display("FAIL busy_at_done: got %b want 0", busy);
                    end
                end
            end
            prev_rv = resp_valid;
        end
    end

    task automatic do_start(input logic [C_LENGTH-1:0] s);
        @(negedge clk);
        start  = 1'b1;
        seed   = s;
        ev_cnt = 0;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #2;
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
        total++; if (response !== '0) begin bad++; $display("FAIL rst_response: got %h want 0", response); end
        total++; if (unstable_cnt !== '0) begin bad++; $display("FAIL rst_unstable: got %0d want 0", unstable_cnt); end
        total++; if (dut.launch !== 1'b0) begin bad++; $display("FAIL rst_launch: got %b want 0", dut.launch); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_xor_zero;
        bit ok;
        mode = 0;
        force dut.arb_q = 2'b11;
        sb.push_back('{resp: 8'h00, unst: '0, lat: LATENCY});
        do_start(16'h8001);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b want 1", busy); end
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL xor_zero_timeout: got no response want one"); end
        repeat (10) @(posedge clk);
        #1;
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL valid_hold: got %b want 1", resp_valid); end
    endtask

    task automatic test_xor_one;
        bit ok;
        mode = 1;
        force dut.arb_q = 2'b01;
        sb.push_back('{resp: 8'hFF, unst: '0, lat: LATENCY});
        do_start(16'h5A5A);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL xor_one_timeout: got no response want one"); end
    endtask

    task automatic test_alternating;
        bit ok;
        logic [UW-1:0] exp_unst;
`ifdef PUF_STABILITY_EN
        exp_unst = UW'(RESP_BITS);
`else
        exp_unst = '0;
`endif
        mode = 2;
        sb.push_back('{resp: 8'hFF, unst: exp_unst, lat: LATENCY});
        do_start(16'h1357);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL alt_timeout: got no response want one"); end
    endtask

    task automatic test_challenge;
        bit ok;
        logic [C_LENGTH-1:0] c0;
        mode = 0;
        force dut.arb_q = 2'b11;
        sb.push_back('{resp: 8'h00, unst: '0, lat: LATENCY});
        do_start(16'h8001);
        repeat (5) @(posedge clk);
        #1;
        c0 = dut.chain_chal[0];
        total++; if (c0 !== 16'h8001) begin bad++; $display("FAIL chal0_bit0: got %h want 8001", c0); end
        c0 = dut.chain_chal[1];
        total++; if (c0 !== 16'h0003) begin bad++; $display("FAIL chal1_bit0: got %h want 0003", c0); end
        repeat (41) @(posedge clk);
        #1;
        c0 = dut.chain_chal[0];
        total++; if (c0 !== 16'h0002) begin bad++; $display("FAIL chal0_bit1: got %h want 0002", c0); end
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL chal_timeout: got no response want one"); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [C_LENGTH-1:0] want, c0;
        mode = 1;
        force dut.arb_q = 2'b01;
        sb.push_back('{resp: 8'hFF, unst: '0, lat: LATENCY});
        do_start(16'h8001);
        repeat (99) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        seed  = 16'h1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        want = step(step(16'h8001));
        c0 = dut.chain_chal[0];
        total++; if (c0 !== want) begin bad++; $display("FAIL restart_chal: got %h want %h", c0, want); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy: got %b want 1", busy); end
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL restart_timeout: got no response want one"); end
    endtask

    task automatic test_reset_abort;
        bit ok;
        mode = 1;
        force dut.arb_q = 2'b01;
        do_start(16'h8001);
        repeat (150) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", resp_valid); end
        total++; if (response !== '0) begin bad++; $display("FAIL abort_response: got %h want 0", response); end
        total++; if (dut.launch !== 1'b0) begin bad++; $display("FAIL abort_launch: got %b want 0", dut.launch); end
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{resp: 8'hFF, unst: '0, lat: LATENCY});
        do_start(16'hC3C3);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL abort_restart_timeout: got no response want one"); end
    endtask

    initial begin
        test_reset;
        test_xor_zero;
        test_xor_one;
        test_alternating;
        test_challenge;
        test_back_to_back;
        test_reset_abort;
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
